// File: rtl/irq_vector_ctrl_pkg.sv
// rtl/irq_vector_ctrl_pkg.sv - shared constants and types for the interrupt vectoring controller
//
// Purpose:
//   Register word addresses, the "no source" id encoding, the position of the
//   valid flag in the ID register and the largest supported source count.
//   Imported by every other file of the block with import irq_vector_ctrl_pkg::*.
//
// Ports: none (package).

package irq_vector_ctrl_pkg;

    // Largest number of sources; 4'hF is reserved as the "none" id.
    localparam int MAX_IRQ = 15;

    localparam logic [3:0] ID_NONE = 4'hF;

    // Bit of the ID register carrying the valid flag.
    localparam int ID_VALID_BIT = 15;

    typedef enum logic [2:0] {
        ADDR_PENDING = 3'd0,
        ADDR_RSVD    = 3'd1,
        ADDR_MASK    = 3'd2,
        ADDR_MODE    = 3'd3,
        ADDR_ACTIVE  = 3'd4,
        ADDR_ID      = 3'd5,
        ADDR_SWTRIG  = 3'd6,
        ADDR_CTRL    = 3'd7
    } reg_addr_e;

    // Decoded register-bus strobes for one cycle.
    typedef struct packed {
        logic wr;
        logic rd;
    } bus_strobe_t;

    // Write strobe is chipselect qualified by the active-low write_n.
    function automatic bus_strobe_t decode_strobe(input logic chipselect, input logic write_n);
        bus_strobe_t s;
        s.wr = chipselect & ~write_n;
        s.rd = chipselect &  write_n;
        return s;
    endfunction

endpackage

// File: rtl/irq_vector_ctrl_if.sv
// rtl/irq_vector_ctrl_if.sv - 16-bit register slave bus between CPU and interrupt controller
//
// Purpose:
//   Bundles the register-access signals (timer-peripheral style: 3-bit word
//   address, 16-bit data, 1-cycle registered read latency).
//
// Signals:
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   address     register word address
//   writedata   write data
//   readdata    registered read data (driven by the slave)
//
// Modports:
//   master  drives select/strobe/address/data, receives readdata
//   slave   receives select/strobe/address/data, drives readdata

interface irq_vector_ctrl_if;

    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output chipselect,
        output write_n,
        output address,
        output writedata,
        input  readdata
    );

    modport slave (
        input  chipselect,
        input  write_n,
        input  address,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-first priority encoder
//
// Purpose:
//   Returns the index of the lowest set bit of req_i, or ID_NONE when no bit
//   is set. Shared by the registered irq_id output and by ID register reads /
//   acknowledges so both always agree on the winning source.
//
// Parameters:
//   N         request width, 1..MAX_IRQ
//
// Ports:
//   req_i     in   N   request vector, bit 0 highest priority
//   id_o      out  4   winning index, ID_NONE when valid_o is 0
//   valid_o   out  1   at least one request bit set

module irq_prio_enc
    import irq_vector_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [3:0]   id_o,
    output logic         valid_o
);

    // Scan from the top down so the last (lowest) set bit overwrites higher ones.
    always_comb begin
        id_o    = ID_NONE;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                id_o    = 4'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// rtl/irq_vector_ctrl.sv - interrupt aggregator and vectoring stage for the Nios II CPU
//
// Purpose:
//   Collects N_IRQ peripheral interrupt lines, latches (edge mode) or follows
//   (level mode) each one into a pending register, masks them, and presents a
//   registered aggregate request plus the highest-priority source index.
//
// Build option:
//   IRQ_VECTOR_CTRL_SYNC_EN  when defined, each irq_in bit passes a 2-flop
//                            synchronizer first (asynchronous sources allowed,
//                            request latency 4 cycles instead of 2).
//
// Parameters:
//   N_IRQ        number of interrupt sources, 1..15
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      synchronous active-high reset
//   irq_in       in   N_IRQ  interrupt requests, active-high, bit 0 highest priority
//   bus          slave       register bus (chipselect/write_n/address/writedata/readdata)
//   irq_out      out  1      registered aggregate request, reset 0
//   irq_id       out  4      registered winning index, reset 4'hF (none)
//
// Registers (word address):
//   0 PENDING  raw pending, W1C for edge-mode bits
//   1 reserved, reads 0
//   2 MASK     RW
//   3 MODE     RW, 1 = edge, 0 = level
//   4 ACTIVE   RO, pending & mask
//   5 ID       {valid, 11'b0, id}; any write acknowledges the current winner
//   6 SWTRIG   write sets pending of edge-mode sources, reads 0
//   7 CTRL     bit0 global enable

module irq_vector_ctrl
    import irq_vector_ctrl_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    irq_vector_ctrl_if.slave bus,
    output logic             irq_out,
    output logic [3:0]       irq_id
);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] irq_s;

`ifdef IRQ_VECTOR_CTRL_SYNC_EN
    logic [N_IRQ-1:0] sync1_q;
    logic [N_IRQ-1:0] sync2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_in;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_in;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] irq_d_q;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic [N_IRQ-1:0] mask_q,    mask_d;
    logic [N_IRQ-1:0] mode_q,    mode_d;
    logic             en_q,      en_d;
    logic [15:0]      readdata_q, readdata_d;
    logic             irq_out_q, irq_out_d;
    logic [3:0]       irq_id_q,  irq_id_d;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    bus_strobe_t      strobe;
    logic [N_IRQ-1:0] wdata_n;
    logic             unused_wdata;

    assign strobe  = decode_strobe(bus.chipselect, bus.write_n);
    assign wdata_n = bus.writedata[N_IRQ-1:0];

    // Data bits above the source count are don't-care on writes.
    assign unused_wdata = ^bus.writedata;

    // ------------------------------------------------------------------
    // Priority encode of the masked pending set
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] active;
    logic [3:0]       enc_id;
    logic             enc_valid;

    assign active = pending_q & mask_q;

    irq_prio_enc #(
        .N (N_IRQ)
    ) u_prio_enc (
        .req_i   (active),
        .id_o    (enc_id),
        .valid_o (enc_valid)
    );

    // ------------------------------------------------------------------
    // Pending / configuration next state
    // ------------------------------------------------------------------
    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] w1c;
    logic [N_IRQ-1:0] ack;
    logic [N_IRQ-1:0] swtrig;

    // irq_d_q resets to 0, so a line already high at reset release looks
    // like a rising edge on the first cycle.
    assign rise = irq_s & ~irq_d_q;

    always_comb begin
        w1c    = '0;
        ack    = '0;
        swtrig = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        en_d   = en_q;

        if (strobe.wr) begin
            case (bus.address)
                ADDR_PENDING: w1c    = wdata_n;
                ADDR_MASK:    mask_d = wdata_n;
                ADDR_MODE:    mode_d = wdata_n;
                ADDR_SWTRIG:  swtrig = wdata_n;
                ADDR_CTRL:    en_d   = bus.writedata[0];
                ADDR_ID: begin
                    // Acknowledge the source a concurrent ID read would return.
                    for (int i = 0; i < N_IRQ; i++) begin
                        ack[i] = enc_valid && (enc_id == 4'(i));
                    end
                end
                default: ;
            endcase
        end
    end

    // Edge bits: sticky, set beats clear. Level bits: follow the input, so
    // an edge-to-level switch overwrites and a level-to-edge switch simply
    // keeps whatever was last sampled. Software clears/sets only reach
    // edge-mode bits because they sit inside the mode_q term.
    assign pending_d = (mode_q & ((pending_q & ~(w1c | ack)) | rise | swtrig))
                     | (~mode_q & irq_s);

    // ------------------------------------------------------------------
    // Read mux (1-cycle registered)
    // ------------------------------------------------------------------
    logic [15:0] rdata_c;

    always_comb begin
        rdata_c = '0;
        case (bus.address)
            ADDR_PENDING: rdata_c[N_IRQ-1:0] = pending_q;
            ADDR_MASK:    rdata_c[N_IRQ-1:0] = mask_q;
            ADDR_MODE:    rdata_c[N_IRQ-1:0] = mode_q;
            ADDR_ACTIVE:  rdata_c[N_IRQ-1:0] = active;
            ADDR_ID: begin
                rdata_c[ID_VALID_BIT] = enc_valid;
                rdata_c[3:0]          = enc_id;
            end
            ADDR_CTRL:    rdata_c[0] = en_q;
            default:      rdata_c = '0;
        endcase
    end

    assign readdata_d = strobe.rd ? rdata_c : readdata_q;

    // ------------------------------------------------------------------
    // CPU request outputs
    // ------------------------------------------------------------------
    assign irq_out_d = en_q & (|active);
    assign irq_id_d  = enc_id;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d_q    <= '0;
            pending_q  <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            en_q       <= 1'b0;
            readdata_q <= '0;
            irq_out_q  <= 1'b0;
            irq_id_q   <= ID_NONE;
        end else begin
            irq_d_q    <= irq_s;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            en_q       <= en_d;
            readdata_q <= readdata_d;
            irq_out_q  <= irq_out_d;
            irq_id_q   <= irq_id_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq_out      = irq_out_q;
    assign irq_id       = irq_id_q;

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// tb/tb_irq_vector_ctrl.sv - directed self-checking bench for irq_vector_ctrl

module tb_irq_vector_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic         irq_out;
    logic [3:0]   irq_id;
    logic [15:0]  rd;

    int errors = 0;
    int checks = 0;

    irq_vector_ctrl_if bus ();

    irq_vector_ctrl #(
        .N_IRQ (N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .irq_in  (irq_in),
        .bus     (bus),
        .irq_out (irq_out),
        .irq_id  (irq_id)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = a;
        tick();
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        irq_in         = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 16'h0000;
        tick();
        tick();

        // Reset state
        check("rst_irq_out", {15'b0, irq_out}, 16'h0000);
        check("rst_irq_id", {12'b0, irq_id}, 16'h000F);
        check("rst_readdata", bus.readdata, 16'h0000);
        reset = 1'b0;
        tick();
        bus_read(3'd5, rd);
        check("rst_id_reg", rd, 16'h000F);

        // 1: edge bit 2 pulse, ID read, ack
        bus_write(3'd3, 16'h0004);
        bus_write(3'd2, 16'h0004);
        bus_write(3'd7, 16'h0001);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        check("e1_out_k", {15'b0, irq_out}, 16'h0000);
        tick();
        check("e1_out_k1", {15'b0, irq_out}, 16'h0001);
        check("e1_id", {12'b0, irq_id}, 16'h0002);
        bus_read(3'd5, rd);
        check("e1_id_read", rd, 16'h8002);
        bus_write(3'd5, 16'h0000);
        check("e1_ack_out_k", {15'b0, irq_out}, 16'h0001);
        tick();
        check("e1_ack_out_k1", {15'b0, irq_out}, 16'h0000);
        check("e1_ack_id", {12'b0, irq_id}, 16'h000F);

        // 2: level bit 0, W1C ignored
        bus_write(3'd3, 16'h0000);
        bus_write(3'd2, 16'h0001);
        irq_in = 8'h01;
        tick();
        tick();
        check("l2_out", {15'b0, irq_out}, 16'h0001);
        check("l2_id", {12'b0, irq_id}, 16'h0000);
        bus_write(3'd0, 16'h0001);
        tick();
        check("l2_w1c_out", {15'b0, irq_out}, 16'h0001);
        bus_read(3'd0, rd);
        check("l2_w1c_pend", rd, 16'h0001);
        irq_in = 8'h00;
        tick();
        check("l2_drop_k", {15'b0, irq_out}, 16'h0001);
        tick();
        check("l2_drop_k1", {15'b0, irq_out}, 16'h0000);

        // 3: edge bits 1 and 5, priority and successive acks
        bus_write(3'd3, 16'h0022);
        bus_write(3'd2, 16'h0022);
        irq_in = 8'h22;
        tick();
        irq_in = 8'h00;
        tick();
        check("p3_id_first", {12'b0, irq_id}, 16'h0001);
        bus_read(3'd4, rd);
        check("p3_active", rd, 16'h0022);
        bus_write(3'd5, 16'h0000);
        tick();
        check("p3_id_second", {12'b0, irq_id}, 16'h0005);
        bus_write(3'd5, 16'h0000);
        tick();
        check("p3_id_none", {12'b0, irq_id}, 16'h000F);
        check("p3_out_none", {15'b0, irq_out}, 16'h0000);

        // 4: same-cycle rising edge and W1C on bit 3 -> set wins
        bus_write(3'd3, 16'h0008);
        irq_in = 8'h08;
        bus_write(3'd0, 16'h0008);
        irq_in = 8'h00;
        bus_read(3'd0, rd);
        check("s4_set_wins", rd, 16'h0008);
        bus_write(3'd0, 16'h0008);
        bus_read(3'd0, rd);
        check("s4_w1c_clears", rd, 16'h0000);

        // 5: masking and global enable
        bus_write(3'd3, 16'h0010);
        bus_write(3'd6, 16'h0010);
        bus_write(3'd2, 16'h0000);
        tick();
        tick();
        check("m5_mask0_out", {15'b0, irq_out}, 16'h0000);
        bus_read(3'd4, rd);
        check("m5_mask0_active", rd, 16'h0000);
        bus_write(3'd7, 16'h0000);
        bus_write(3'd2, 16'h0010);
        tick();
        tick();
        bus_read(3'd4, rd);
        check("m5_en0_active", rd, 16'h0010);
        check("m5_en0_out", {15'b0, irq_out}, 16'h0000);
        bus_read(3'd6, rd);
        check("m5_swtrig_reads0", rd, 16'h0000);
        bus_read(3'd1, rd);
        check("m5_rsvd_reads0", rd, 16'h0000);
        bus_write(3'd0, 16'h0010);
        bus_write(3'd3, 16'h0040);
        bus_write(3'd2, 16'h0040);
        bus_write(3'd7, 16'h0001);
        bus_write(3'd6, 16'h0040);
        tick();
        check("m5_sw_out", {15'b0, irq_out}, 16'h0001);
        check("m5_sw_id", {12'b0, irq_id}, 16'h0006);

        // 6: reset discards pending 0x00FF
        bus_write(3'd3, 16'h00FF);
        bus_write(3'd6, 16'h00FF);
        bus_read(3'd0, rd);
        check("r6_pend_ff", rd, 16'h00FF);
        reset = 1'b1;
        tick();
        check("r6_readdata", bus.readdata, 16'h0000);
        check("r6_out", {15'b0, irq_out}, 16'h0000);
        check("r6_id", {12'b0, irq_id}, 16'h000F);
        reset = 1'b0;
        bus_read(3'd0, rd);
        check("r6_pend", rd, 16'h0000);
        bus_read(3'd2, rd);
        check("r6_mask", rd, 16'h0000);
        bus_read(3'd3, rd);
        check("r6_mode", rd, 16'h0000);
        bus_read(3'd7, rd);
        check("r6_ctrl", rd, 16'h0000);

        // Source held high across reset release registers on the first cycle
        reset  = 1'b1;
        irq_in = 8'h10;
        tick();
        reset = 1'b0;
        tick();
        bus_read(3'd0, rd);
        check("r6_held_pend", rd, 16'h0010);
        // Level-to-edge switch keeps the pending value after the line drops
        bus_write(3'd3, 16'h0010);
        irq_in = 8'h00;
        tick();
        bus_read(3'd0, rd);
        check("r6_l2e_retain", rd, 16'h0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
